// File: rtl/caliptra_prim_reg_adapter_pkg.sv
// Shared types and helpers for the register-bus adapter.
// Holds the FSM state encoding and the byte-enable mask helper.
package caliptra_prim_reg_adapter_pkg;

    localparam int unsigned RegDw = 32;
    localparam int unsigned BeW   = RegDw / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } adapter_state_e;

    function automatic logic [RegDw-1:0] be_to_mask(
        input logic [BeW-1:0] be
    );
        logic [RegDw-1:0] mask;
        mask = '0;
        for (int b = 0; b < BeW; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/caliptra_prim_reg_be_merge.sv
// Combinational byte-enable merge of write data over the current qs.
// Enabled bytes come from wdata, the rest keep the register value.
module caliptra_prim_reg_be_merge
    import caliptra_prim_reg_adapter_pkg::*;
(
    input  logic [RegDw-1:0] qs,
    input  logic [RegDw-1:0] wdata,
    input  logic [BeW-1:0]   be,
    output logic [RegDw-1:0] merged
);

    logic [RegDw-1:0] mask;

    always_comb begin
        mask   = be_to_mask(be);
        merged = (qs & ~mask) | (wdata & mask);
    end

endmodule

// File: rtl/caliptra_prim_reg_adapter.sv
// Valid/ready register-bus request to per-register we/re pulses.
// Three-state FSM: accept, one-cycle access pulse, held response.
module caliptra_prim_reg_adapter
    import caliptra_prim_reg_adapter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int NumRegs = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wd_o,
    input  logic [NumRegs*DW-1:0] reg_qs_i
);

    localparam int IdxW = AW - 2;
    localparam logic [IdxW:0] NumRegsW = (IdxW+1)'(NumRegs);

    adapter_state_e state;

    logic [IdxW-1:0]    idx_q;
    logic               write_q;
    logic               err_q;

    logic [IdxW-1:0]    req_idx;
    logic               req_err;
    logic [NumRegs-1:0] req_hot;
    logic [DW-1:0]      req_qs;
    logic [DW-1:0]      cur_qs;
    logic [DW-1:0]      merged;

    assign req_idx = req_addr_i[AW-1:2];

    always_comb begin
        req_err = (req_addr_i[1:0] != 2'b00) ||
                  ({1'b0, req_idx} >= NumRegsW);
    end

    // Loop-based muxes keep out-of-range indices from slicing past qs.
    always_comb begin
        req_hot = '0;
        req_qs  = '0;
        cur_qs  = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (req_idx == IdxW'(i)) begin
                req_hot[i] = 1'b1;
                req_qs     = reg_qs_i[i*DW +: DW];
            end
            if (idx_q == IdxW'(i)) begin
                cur_qs = reg_qs_i[i*DW +: DW];
            end
        end
    end

    caliptra_prim_reg_be_merge u_be_merge (
        .qs     (req_qs),
        .wdata  (req_wdata_i),
        .be     (req_be_i),
        .merged (merged)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            reg_we_o    <= '0;
            reg_re_o    <= '0;
            reg_wd_o    <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state       <= ACCESS;
                        req_ready_o <= 1'b0;
                        idx_q       <= req_idx;
                        write_q     <= req_write_i;
                        err_q       <= req_err;
                        if (!req_err) begin
                            if (req_write_i) begin
                                if (|req_be_i) begin
                                    reg_we_o <= req_hot;
                                    reg_wd_o <= merged;
                                end
                            end else begin
                                reg_re_o <= req_hot;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // qs is sampled while re is high: pre-clear value.
                    state       <= RESP;
                    reg_we_o    <= '0;
                    reg_re_o    <= '0;
                    reg_wd_o    <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= err_q;
                    rsp_rdata_o <= (!err_q && !write_q) ? cur_qs : '0;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_prim_reg_adapter.sv
// Directed self-checking bench for the register-bus adapter.
// Walks reads, merged writes, errors, backpressure and reset.
module tb_caliptra_prim_reg_adapter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NR-1:0]     reg_we;
    logic [NR-1:0]     reg_re;
    logic [DW-1:0]     reg_wd;
    logic [NR*DW-1:0]  reg_qs;

    int n_checks;
    int n_fail;

    caliptra_prim_reg_adapter #(
        .AW      (AW),
        .DW      (DW),
        .NumRegs (NR)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_wd_o    (reg_wd),
        .reg_qs_i    (reg_qs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_qs(input int i, input logic [31:0] v);
        reg_qs[i*DW +: DW] = v;
    endtask

    // One full access with the expected pulse and response.
    task automatic access(input string tag, input logic wr,
                          input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [15:0] e_we,
                          input logic [15:0] e_re, input logic [31:0] e_wd,
                          input logic [31:0] e_rd, input logic e_err);
        check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        check({tag, ".we"}, 32'(reg_we), 32'(e_we));
        check({tag, ".re"}, 32'(reg_re), 32'(e_re));
        check({tag, ".wd"}, reg_wd, e_wd);
        check({tag, ".acc_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".acc_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rdata"}, rsp_rdata, e_rd);
        check({tag, ".err"}, 32'(rsp_err), 32'(e_err));
        check({tag, ".rsp_we"}, 32'(reg_we | reg_re), 32'd0);
        check({tag, ".rsp_wd"}, reg_wd, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".done_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        reg_qs    = '0;
        for (int i = 0; i < NR; i++) set_qs(i, 32'h1000_0000 + 32'(i));
        set_qs(3, 32'hDEAD_BEEF);
        set_qs(5, 32'h1122_3344);
        set_qs(7, 32'h0BAD_F00D);
        set_qs(0, 32'h0000_00A5);

        #12;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.outs", 32'(reg_we | reg_re) | reg_wd | rsp_rdata |
              32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        access("rd3", 1'b0, 8'h0C, 32'h0, 4'h0,
               16'h0000, 16'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("wr5", 1'b1, 8'h14, 32'hAABB_CCDD, 4'b0101,
               16'h0020, 16'h0000, 32'h11BB_33DD, 32'h0, 1'b0);
        access("wr15", 1'b1, 8'h3C, 32'hCAFE_0123, 4'b1111,
               16'h8000, 16'h0000, 32'hCAFE_0123, 32'h0, 1'b0);
        access("wr5hi", 1'b1, 8'h14, 32'hAABB_CCDD, 4'b1000,
               16'h0020, 16'h0000, 32'hAA22_3344, 32'h0, 1'b0);
        access("wr41", 1'b1, 8'h41, 32'hFFFF_FFFF, 4'b1111,
               16'h0000, 16'h0000, 32'h0, 32'h0, 1'b1);
        access("rd40", 1'b0, 8'h40, 32'h0, 4'h0,
               16'h0000, 16'h0000, 32'h0, 32'h0, 1'b1);
        access("rd02", 1'b0, 8'h02, 32'h0, 4'h0,
               16'h0000, 16'h0000, 32'h0, 32'h0, 1'b1);
        access("wrbe0", 1'b1, 8'h00, 32'h1234_5678, 4'b0000,
               16'h0000, 16'h0000, 32'h0, 32'h0, 1'b0);

        // Backpressure with a competing request held on the bus.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h1C;
        tick();
        req_addr  = 8'h04;
        check("bp.re", 32'(reg_re), 32'h0080);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp.valid", 32'(rsp_valid), 32'd1);
            check("bp.rdata", rsp_rdata, 32'h0BAD_F00D);
            check("bp.ready", 32'(req_ready), 32'd0);
            check("bp.nopulse", 32'(reg_we | reg_re), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp.after_ready", 32'(req_ready), 32'd1);
        check("bp.after_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp.next_re", 32'(reg_re), 32'h0002);
        tick();
        check("bp.next_rdata", rsp_rdata, 32'h1000_0001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while the access pulse is high.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h08;
        req_wdata = 32'h5555_AAAA;
        req_be    = 4'b1111;
        tick();
        req_valid = 1'b0;
        check("mid.we", 32'(reg_we), 32'h0004);
        rst_n = 1'b0;
        #1;
        check("mid.we_clr", 32'(reg_we | reg_re), 32'd0);
        check("mid.wd_clr", reg_wd, 32'd0);
        check("mid.ready", 32'(req_ready), 32'd1);
        check("mid.valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        access("rd0", 1'b0, 8'h00, 32'h0, 4'h0,
               16'h0000, 16'h0001, 32'h0, 32'h0000_00A5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/caliptra_prim_reg_adapter.md
Name: caliptra_prim_reg_adapter

Overview:
- Converts a simple valid/ready register-bus request into the per-register `we`/`wd` write pulses and `re` read pulses consumed by a bank of subregister slices.
- Collects the slices' software-visible values (`qs`) to return read data.
- Sits between the bus-protocol front end and the register bank in each register-top block.
- Handles word decode, byte-enable merging (read-modify-write against `qs`), error detection, and a held response handshake.

Parameters:
- AW, 8, byte-address width.
- DW, 32, data width; must be 32.
- NumRegs, 16, number of 32-bit registers mapped from address 0; 1..2^(AW-2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_be_i  in  DW/8  byte enables (writes only)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  DW  read data
- rsp_err_o  out  1  access error
- reg_we_o  out  NumRegs  one-hot write pulse per register
- reg_re_o  out  NumRegs  one-hot read pulse per register (for RC slices)
- reg_wd_o  out  DW  merged write data, shared by all registers
- reg_qs_i  in  NumRegs*DW  concatenated `qs` of all registers; reg i occupies [i*DW +: DW]

Behaviour:
- Clock and reset: clk_i is the clock; rst_ni is the reset, asynchronous, active-low.
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; reg_we_o=0; reg_re_o=0; reg_wd_o=0.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register write, addr, wdata and be, then go to ACCESS.
  - Error is computed at acceptance: addr[1:0]!=0, or addr[AW-1:2]>=NumRegs.
- ACCESS (exactly 1 cycle), req_ready_o=0:
  - No error, write, be!=0: reg_we_o[idx]=1; reg_wd_o = (qs_idx & ~m) | (wdata & m), where m is be expanded per byte.
  - No error, write, be==0: no pulse; response OK.
  - No error, read: reg_re_o[idx]=1; rsp_rdata_o <= qs_idx sampled this cycle, i.e. the pre-clear value for RC slices.
  - Error: no we/re pulse; rdata=0; err=1.
  - Then go to RESP.
- RESP:
  - rsp_valid_o=1; rdata and err held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE and clear rdata and err.
- Outputs are registered. reg_we_o and reg_re_o are single-cycle pulses; at most one bit of the two vectors combined is set.
- reg_wd_o is 0 outside ACCESS.
- Latency: accept at cycle 0, pulse at cycle 1, rsp_valid_o at cycle 2. Minimum spacing is 3 cycles per access. No request is accepted while a response is pending.
- A write response carries rdata=0.
- Reset mid-ACCESS or mid-RESP: immediately back to IDLE with all outputs at reset values. A dropped pulse is acceptable.
- rsp_ready_i asserted outside RESP is ignored.
- req_* inputs are ignored when req_ready_o=0.

Decomposition:
- caliptra_prim_reg_adapter_pkg holds:
  - the state enum (adapter_state_e: IDLE/ACCESS/RESP);
  - the constant BeW=DW/8;
  - the function be_to_mask(be) returning the DW-bit mask.
- One sub-module, caliptra_prim_reg_be_merge: combinational merge of qs, wdata and be. It is separately unit-testable.
- The FSM and decode live in the top module.

Test Plan:
- Read, NumRegs=16, reg 3 qs=0xDEAD_BEEF; read addr 0x0C → reg_re_o=0x0008 at cycle 1; rsp at cycle 2 with rdata=0xDEAD_BEEF, err=0.
- Partial write, reg 5 qs=0x1122_3344; write addr 0x14, wdata=0xAABB_CCDD, be=0b0101 → reg_we_o=0x0020, reg_wd_o=0x11BB_33DD.
- Errors:
  - write addr 0x41 → no we pulse, err=1, rdata=0;
  - read addr 0x40 (idx 16) → no re pulse, err=1.
- Backpressure: rsp_ready_i low for 5 cycles → rsp_valid_o and rdata stable, req_ready_o=0 throughout; on handshake, the next request is accepted 1 cycle later.
- be==0 write to 0x00 → no we pulse, rsp err=0.
- Reset mid-operation:
  - assert rst_ni=0 during ACCESS → all outputs 0 immediately, FSM in IDLE;
  - after release, a read of reg 0 completes normally.
